// File: rtl/audio_dac_serializer.sv
// Stereo sample FIFO and serializer driving the WM8731 AUD_DACDAT pin from the Clk domain.
// Optional DAC_HOLD_LAST_EN: an underflowed frame repeats the last popped sample instead of muting.
//
// state | meaning
// IDLE  | not aligned to a frame; output held at 0 until the next LRCK 1->0
// LEFT  | serialising the left channel
// RIGHT | serialising the right channel
module audio_dac_serializer #(
    parameter int SAMPLE_W   = 16,
    parameter int SLOT_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int I2S_MODE   = 1
) (
    input  logic                          Clk,
    input  logic                          reset,
    input  logic                          AUD_BCLK,
    input  logic                          AUD_DACLRCK,
    input  logic [2*SAMPLE_W-1:0]         s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    output logic                          AUD_DACDAT,
    output logic                          Send_Done,
    output logic                          underflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LVL_W    = $clog2(FIFO_DEPTH) + 1;
    localparam int LOST_CNT = SLOT_W + SLOT_W / 2;
    localparam int CNT_W    = $clog2(LOST_CNT + 1);
    localparam int I2S_OFS  = (I2S_MODE != 0) ? 1 : 0;
    // Only when slot and sample widths match does the I2S-delayed LSB spill into the next slot.
    localparam bit CARRY_OK = (I2S_MODE != 0) && (SLOT_W == SAMPLE_W);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LEFT  = 2'd1,
        ST_RIGHT = 2'd2
    } state_t;

    logic              bclk_s1, bclk_sync, bclk_d;
    logic              lr_s1, lr_sync;
    logic              lr_cur, lr_prev;
    logic              bclk_fall, slot_start, frame_load;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc, bit_idx;
    logic              dat_q, dat_d;
    logic              emit, cur_bit;
    logic [SAMPLE_W-1:0] left_q, right_q, chan, chan_sh;

    logic [2*SAMPLE_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [LVL_W-1:0]  count_q, count_d;
    logic              ready_q;
    logic              push, pop, fifo_empty;
    logic [2*SAMPLE_W-1:0] head, fill_word, load_word;
    logic              send_done_q, underflow_q;

    // ---------------- input synchronisers and edge detect ----------------
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            bclk_s1   <= 1'b0;
            bclk_sync <= 1'b0;
            bclk_d    <= 1'b0;
            lr_s1     <= 1'b0;
            lr_sync   <= 1'b0;
            lr_prev   <= 1'b0;
        end else begin
            bclk_s1   <= AUD_BCLK;
            bclk_sync <= bclk_s1;
            bclk_d    <= bclk_sync;
            lr_s1     <= AUD_DACLRCK;
            lr_sync   <= lr_s1;
            if (bclk_fall) begin
                lr_prev <= lr_cur;
            end
        end
    end

    assign bclk_fall  = bclk_d & ~bclk_sync;
    assign lr_cur     = lr_sync;
    assign slot_start = bclk_fall && (lr_cur != lr_prev);
    assign frame_load = slot_start && !lr_cur && (state_q != ST_LEFT);

    // ---------------- sample FIFO ----------------
    assign fifo_empty = (count_q == '0);
    assign push       = s_valid && ready_q;
    assign pop        = frame_load && !fifo_empty;
    assign head       = mem[rd_ptr];

    always_ff @(posedge Clk) begin
        if (push) begin
            mem[wr_ptr] <= s_data;
        end
    end

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            ready_q <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count_q <= count_d;
            ready_q <= (count_d != LVL_W'(FIFO_DEPTH));
        end
    end

    // ---------------- underflow fill value ----------------
`ifdef DAC_HOLD_LAST_EN
    logic [2*SAMPLE_W-1:0] last_q;

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            last_q <= '0;
        end else if (pop) begin
            last_q <= head;
        end
    end

    assign fill_word = last_q;
`else
    assign fill_word = '0;
`endif

    assign load_word = pop ? head : fill_word;

    // ---------------- bit selection ----------------
    assign cnt_inc = (cnt_q == CNT_W'(LOST_CNT)) ? cnt_q : cnt_q + 1'b1;
    assign bit_idx = cnt_inc - CNT_W'(I2S_OFS);
    assign emit    = (bit_idx < CNT_W'(SAMPLE_W)) && (bit_idx < CNT_W'(SLOT_W));
    assign chan    = (state_q == ST_LEFT) ? left_q : right_q;
    assign chan_sh = chan << bit_idx;
    assign cur_bit = chan_sh[SAMPLE_W-1];

    // ---------------- state machine ----------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dat_d   = dat_q;
        if (bclk_fall) begin
            dat_d = 1'b0;
            if (slot_start) begin
                cnt_d = '0;
                if (!lr_cur) begin
                    if (state_q == ST_LEFT) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_LEFT;
                        if (I2S_MODE == 0) begin
                            dat_d = load_word[2*SAMPLE_W-1];
                        end else if (CARRY_OK && state_q == ST_RIGHT) begin
                            dat_d = right_q[0];
                        end
                    end
                end else begin
                    if (state_q == ST_LEFT) begin
                        state_d = ST_RIGHT;
                        if (I2S_MODE == 0) begin
                            dat_d = right_q[SAMPLE_W-1];
                        end else if (CARRY_OK) begin
                            dat_d = left_q[0];
                        end
                    end else if (state_q == ST_RIGHT) begin
                        state_d = ST_IDLE;
                    end
                end
            end else begin
                cnt_d = cnt_inc;
                // A slot running half again past its length means an LRCK edge was lost.
                if (state_q != ST_IDLE) begin
                    if (cnt_inc == CNT_W'(LOST_CNT)) begin
                        state_d = ST_IDLE;
                    end else if (emit) begin
                        dat_d = cur_bit;
                    end
                end
            end
        end
    end

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            dat_q       <= 1'b0;
            left_q      <= '0;
            right_q     <= '0;
            send_done_q <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dat_q       <= dat_d;
            send_done_q <= pop;
            underflow_q <= frame_load && fifo_empty;
            if (frame_load) begin
                left_q  <= load_word[2*SAMPLE_W-1:SAMPLE_W];
                right_q <= load_word[SAMPLE_W-1:0];
            end
        end
    end

    assign AUD_DACDAT = dat_q;
    assign Send_Done  = send_done_q;
    assign underflow  = underflow_q;
    assign s_ready    = ready_q;
    assign fifo_level = count_q;

endmodule

// File: tb/tb_audio_dac_serializer.sv
// Directed bench: an I2S and a left-justified instance share stimulus and are checked against
// hand-computed slot bit patterns, FIFO occupancy and pulse counts.
module tb_audio_dac_serializer;

    localparam int SW = 16;

    logic          Clk = 1'b0;
    logic          reset;
    logic          AUD_BCLK;
    logic          AUD_DACLRCK;
    logic [2*SW-1:0] s_data;
    logic          s_valid;

    logic          rdy_i, rdy_l, dat_i, dat_l, sd_i, sd_l, uf_i, uf_l;
    logic [2:0]    lvl_i, lvl_l;

    int tests  = 0;
    int failed = 0;
    int sd_cnt_i = 0, sd_cnt_l = 0, uf_cnt_i = 0, uf_cnt_l = 0;

    always #5 Clk = ~Clk;

    audio_dac_serializer #(.SAMPLE_W(SW), .SLOT_W(32), .FIFO_DEPTH(4), .I2S_MODE(1)) u_i2s (
        .Clk(Clk), .reset(reset), .AUD_BCLK(AUD_BCLK), .AUD_DACLRCK(AUD_DACLRCK),
        .s_data(s_data), .s_valid(s_valid), .s_ready(rdy_i), .AUD_DACDAT(dat_i),
        .Send_Done(sd_i), .underflow(uf_i), .fifo_level(lvl_i)
    );

    audio_dac_serializer #(.SAMPLE_W(SW), .SLOT_W(32), .FIFO_DEPTH(4), .I2S_MODE(0)) u_lj (
        .Clk(Clk), .reset(reset), .AUD_BCLK(AUD_BCLK), .AUD_DACLRCK(AUD_DACLRCK),
        .s_data(s_data), .s_valid(s_valid), .s_ready(rdy_l), .AUD_DACDAT(dat_l),
        .Send_Done(sd_l), .underflow(uf_l), .fifo_level(lvl_l)
    );

    always @(negedge Clk) begin
        if (sd_i) sd_cnt_i <= sd_cnt_i + 1;
        if (sd_l) sd_cnt_l <= sd_cnt_l + 1;
        if (uf_i) uf_cnt_i <= uf_cnt_i + 1;
        if (uf_l) uf_cnt_l <= uf_cnt_l + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [2*SW-1:0] d);
        @(negedge Clk);
        s_data  = d;
        s_valid = 1'b1;
        @(negedge Clk);
        s_valid = 1'b0;
    endtask

    task automatic fall(input logic lr, output logic di, output logic dl);
        @(negedge Clk);
        AUD_BCLK    = 1'b0;
        AUD_DACLRCK = lr;
        repeat (4) @(negedge Clk);
        di = dat_i;
        dl = dat_l;
        repeat (4) @(negedge Clk);
        AUD_BCLK = 1'b1;
        repeat (7) @(negedge Clk);
    endtask

    task automatic slot(input logic lr, input int n, output logic [63:0] vi, output logic [63:0] vl);
        logic di, dl;
        vi = '0;
        vl = '0;
        for (int i = 0; i < n; i++) begin
            fall(lr, di, dl);
            vi = {vi[62:0], di};
            vl = {vl[62:0], dl};
        end
    endtask

    logic [63:0] vi, vl;
    logic        bi, bl;
    int          base_sd_i, base_sd_l, base_uf_i, base_uf_l;

    initial begin
        reset       = 1'b0;
        AUD_BCLK    = 1'b1;
        AUD_DACLRCK = 1'b1;
        s_data      = '0;
        s_valid     = 1'b0;
        repeat (3) @(negedge Clk);
        check("rst_dat_i2s", 64'(dat_i), 64'd0);
        check("rst_dat_lj", 64'(dat_l), 64'd0);
        check("rst_ready", 64'(rdy_i), 64'd1);
        check("rst_send_done", 64'(sd_i), 64'd0);
        check("rst_underflow", 64'(uf_i), 64'd0);
        check("rst_level", 64'(lvl_i), 64'd0);
        reset = 1'b1;
        repeat (3) @(negedge Clk);

        // Frame A: 0xA5C3_0F0F after a partial right slot
        push(32'hA5C3_0F0F);
        check("a_level", 64'(lvl_i), 64'd1);
        slot(1'b1, 4, vi, vl);
        check("a_partial_i2s", vi, 64'd0);
        check("a_partial_lj", vl, 64'd0);
        slot(1'b0, 32, vi, vl);
        check("a_left_i2s", vi, 64'h52E1_8000);
        check("a_left_lj", vl, 64'hA5C3_0000);
        slot(1'b1, 32, vi, vl);
        check("a_right_i2s", vi, 64'h0787_8000);
        check("a_right_lj", vl, 64'h0F0F_0000);
        check("a_send_done_i2s", 64'(sd_cnt_i), 64'd1);
        check("a_send_done_lj", 64'(sd_cnt_l), 64'd1);
        check("a_underflow", 64'(uf_cnt_i), 64'd0);
        check("a_level_after", 64'(lvl_i), 64'd0);

        // Frame B: 0x1234_8000
        push(32'h1234_8000);
        slot(1'b0, 32, vi, vl);
        check("b_left_i2s", vi, 64'h091A_0000);
        check("b_left_lj", vl, 64'h1234_0000);
        slot(1'b1, 32, vi, vl);
        check("b_right_i2s", vi, 64'h4000_0000);
        check("b_right_lj", vl, 64'h8000_0000);

        // Frame C: FIFO empty at frame start
        base_sd_i = sd_cnt_i;
        base_uf_i = uf_cnt_i;
        base_uf_l = uf_cnt_l;
        slot(1'b0, 32, vi, vl);
`ifdef DAC_HOLD_LAST_EN
        check("c_left_i2s", vi, 64'h091A_0000);
        check("c_left_lj", vl, 64'h1234_0000);
`else
        check("c_left_i2s", vi, 64'd0);
        check("c_left_lj", vl, 64'd0);
`endif
        slot(1'b1, 32, vi, vl);
`ifdef DAC_HOLD_LAST_EN
        check("c_right_i2s", vi, 64'h4000_0000);
        check("c_right_lj", vl, 64'h8000_0000);
`else
        check("c_right_i2s", vi, 64'd0);
        check("c_right_lj", vl, 64'd0);
`endif
        check("c_underflow_i2s", 64'(uf_cnt_i - base_uf_i), 64'd1);
        check("c_underflow_lj", 64'(uf_cnt_l - base_uf_l), 64'd1);
        check("c_no_send_done", 64'(sd_cnt_i - base_sd_i), 64'd0);

        // Fill FIFO with no frames running
        push(32'h1111_2222);
        push(32'h3333_4444);
        push(32'h5555_6666);
        check("fill_ready_3", 64'(rdy_i), 64'd1);
        push(32'h7777_8888);
        check("fill_ready_4", 64'(rdy_i), 64'd0);
        check("fill_level_4", 64'(lvl_i), 64'd4);
        push(32'h9999_AAAA);
        check("fill_level_5th", 64'(lvl_i), 64'd4);
        check("fill_level_5th_lj", 64'(lvl_l), 64'd4);

        // Reset in the middle of a right slot
        slot(1'b0, 32, vi, vl);
        check("r_left_i2s", vi, 64'h0888_8000);
        check("r_left_lj", vl, 64'h1111_0000);
        slot(1'b1, 3, vi, vl);
        check("r_mid_right_lj", vl, 64'b001);
        check("r_level_before", 64'(lvl_i), 64'd3);
        #2 reset = 1'b0;
        #1;
        check("r_dat_i2s", 64'(dat_i), 64'd0);
        check("r_dat_lj", 64'(dat_l), 64'd0);
        check("r_level", 64'(lvl_i), 64'd0);
        check("r_ready", 64'(rdy_l), 64'd1);
        @(negedge Clk);
        reset = 1'b1;
        repeat (2) @(negedge Clk);
        push(32'h7E7E_0180);
        base_sd_i = sd_cnt_i;
        base_sd_l = sd_cnt_l;
        slot(1'b1, 8, vi, vl);
        check("r_no_send_done", 64'(sd_cnt_i - base_sd_i), 64'd0);
        check("r_idle_lj", vl, 64'd0);
        slot(1'b0, 32, vi, vl);
        check("r_send_done_i2s", 64'(sd_cnt_i - base_sd_i), 64'd1);
        check("r_send_done_lj", 64'(sd_cnt_l - base_sd_l), 64'd1);
        check("r2_left_i2s", vi, 64'h3F3F_0000);
        check("r2_left_lj", vl, 64'h7E7E_0000);
        slot(1'b1, 32, vi, vl);
        check("r2_right_i2s", vi, 64'h00C0_0000);
        check("r2_right_lj", vl, 64'h0180_0000);

        // Dropped LRCK rising edge
        push(32'hAAAA_FFFF);
        push(32'h5A5A_C3C3);
        slot(1'b0, 32, vi, vl);
        check("l_left_lj", vl, 64'hAAAA_0000);
        slot(1'b0, 32, vi, vl);
        check("l_stretch_i2s", vi, 64'd0);
        slot(1'b1, 32, vi, vl);
        check("l_right_idle_i2s", vi, 64'd0);
        check("l_right_idle_lj", vl, 64'd0);
        check("l_level_wait", 64'(lvl_i), 64'd1);
        base_sd_i = sd_cnt_i;
        base_uf_i = uf_cnt_i;
        slot(1'b0, 32, vi, vl);
        check("l_resync_send_done", 64'(sd_cnt_i - base_sd_i), 64'd1);
        check("l_resync_underflow", 64'(uf_cnt_i - base_uf_i), 64'd0);
        check("l_resync_left_i2s", vi, 64'h2D2D_0000);
        check("l_resync_left_lj", vl, 64'h5A5A_0000);
        slot(1'b1, 32, vi, vl);
        check("l_resync_right_lj", vl, 64'hC3C3_0000);
        check("l_level_end", 64'(lvl_l), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/audio_dac_serializer.md
# audio_dac_serializer

Parametrised stereo serializer that feeds the WM8731 DAC data pin (AUD_DACDAT) from a small sample FIFO. It runs entirely in the system Clk domain and treats the codec-mastered AUD_BCLK / AUD_DACLRCK as sampled inputs. It supports configurable sample width, slot width, FIFO depth and I2S / left-justified framing. It sits between the vocal-effect processing pipeline, which pushes one stereo sample per frame, and the codec pins.

## Interface
- SAMPLE_W, 16: bits per channel sample, 8..32.
- SLOT_W, 32: BCLK periods per LRCK half-period; must be at least SAMPLE_W.
- FIFO_DEPTH, 4: stereo-sample FIFO entries, power of two, 2..16.
- I2S_MODE, 1: 1 = I2S (MSB one BCLK after LRCK edge); 0 = left-justified (MSB on the LRCK edge).
- Clk  in  1  system clock; must be at least 8× the AUD_BCLK frequency.
- reset  in  1  asynchronous, active-low reset.
- AUD_BCLK  in  1  codec bit clock, asynchronous to Clk.
- AUD_DACLRCK  in  1  codec LR clock; 0 = left slot, 1 = right slot.
- s_data  in  2*SAMPLE_W  stereo sample; left channel in [2*SAMPLE_W-1:SAMPLE_W], right in [SAMPLE_W-1:0]; two's complement.
- s_valid  in  1  s_data valid.
- s_ready  out  1  FIFO not full.
- AUD_DACDAT  out  1  serial data to the codec, registered.
- Send_Done  out  1  one-Clk pulse when a stereo sample is popped into the shifter.
- underflow  out  1  one-Clk pulse when a frame starts with the FIFO empty.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy.

## Operation
- Input synchronisation: AUD_BCLK and AUD_DACLRCK each pass through a 2-flop synchroniser. A BCLK falling edge (bclk_fall) is detected from the synchronised value. LRCK is captured on every bclk_fall as lr_cur. lr_prev holds the previous captured value.
- Slot start: a bclk_fall where lr_cur != lr_prev. If lr_cur = 0, this is a frame start (left slot).
- FIFO: push when s_valid && s_ready. Pop only at a frame start.
  - Push and pop in the same Clk cycle are both honoured when not full.
  - When the FIFO is empty, a simultaneous push is stored but not popped. The frame underflows.
- Frame start with FIFO non-empty: load left and right shift registers; pulse Send_Done.
- Frame start with FIFO empty: pulse underflow; the shift registers load the underflow value (see Configuration).
- Bit counter per slot counts 0..SLOT_W-1 on each bclk_fall after the slot start.
- Output bit index k:
  - I2S_MODE=1: k = counter-1.
  - I2S_MODE=0: k = counter.
- AUD_DACDAT = channel MSB-first bit k when 0 <= k < SAMPLE_W; otherwise 0. The I2S delayed bit of the previous slot carries over naturally into the next slot's first bclk_fall.
- State machine:
  - IDLE (after reset): AUD_DACDAT=0, no pops. Go to LEFT at the first frame start, skipping any partial frame.
  - LEFT: left channel is serialised. Go to RIGHT on a slot start with lr_cur=1.
  - RIGHT: right channel is serialised. Go to LEFT on a frame start, which also pops.
  - If a slot start arrives with an unexpected LRCK value (lost edge), go to IDLE and drive 0 until the next frame start.
- Reset mid-operation: FIFO emptied, state IDLE, all outputs at reset values immediately, since reset is asynchronous.

## Timing
- Reset values: AUD_DACDAT=0, s_ready=1, Send_Done=0, underflow=0, fifo_level=0.
- AUD_DACDAT changes exactly one Clk after the internal bclk_fall, which is 3-4 Clk after the pin edge. It is stable across the following BCLK rising edge given the Clk ≥ 8×BCLK requirement.
- Send_Done / underflow assert in the Clk cycle after the frame-start bclk_fall, for exactly one cycle.
- s_ready and fifo_level are registered. They update the cycle after a push or pop.
- s_ready drops the cycle after the FIFO reaches FIFO_DEPTH entries. A push offered while s_ready=0 is ignored.
- Slot width: bits beyond SLOT_W are never emitted. If LRCK toggles early, the slot restarts.

## Configuration
- DAC_HOLD_LAST_EN defined: on underflow, the shifters reload the last successfully popped stereo sample, so the output is repeated.
  - After reset with no prior pop, the repeated value is zero.
- DAC_HOLD_LAST_EN not defined: on underflow, the shifters load zero (muted frame).
- underflow pulses in both builds.

## Test plan
- SAMPLE_W=16, SLOT_W=32, I2S_MODE=1: push 0xA5C3_0F0F, run 2 frames.
  - Required: left bits A5C3 appear MSB-first starting on the 2nd BCLK fall after LRCK falls, followed by 16 zeros; right 0F0F likewise.
  - Required: Send_Done pulses once.
- I2S_MODE=0, same data: the MSB appears on the same BCLK fall as the LRCK edge.
- Push 5 samples with FIFO_DEPTH=4 and no frames running.
  - Required: s_ready=0 after 4 pushes, the 5th push is ignored, fifo_level=4.
- Empty FIFO at a frame start:
  - Required: underflow pulses; DAC_HOLD_LAST_EN built: previous sample 0x1234_8000 repeated; without the macro: all-zero frame.
- Assert reset during the middle of a right slot:
  - Required: AUD_DACDAT=0 immediately; fifo_level=0; no Send_Done until the next full frame start after release.
- Drop one LRCK edge:
  - Required: FSM goes to IDLE, output 0; resync and pop on the next LRCK 1->0.
